// File: rtl/conv_window_sched_if.sv
// Handshake bundle between the window scheduler, the input bit-RAM and the core.
interface conv_window_sched_if #(
  parameter int unsigned ADDR_W = 10
);
  logic              frame_clr_i;
  logic [ADDR_W-1:0] wr_cnt_i;
  logic              core_bsy_i;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic              px_vld_o;
  logic [3:0]        px_idx_o;
  logic              win_strt_o;
  logic [4:0]        out_row_o;
  logic [4:0]        out_col_o;
  logic              frame_done_o;
  logic              busy_o;

  // Scheduler side
  modport master (
    input  frame_clr_i, wr_cnt_i, core_bsy_i,
    output rd_en_o, rd_addr_o, px_vld_o, px_idx_o, win_strt_o,
           out_row_o, out_col_o, frame_done_o, busy_o
  );

  // RAM / core / frame-control side
  modport slave (
    output frame_clr_i, wr_cnt_i, core_bsy_i,
    input  rd_en_o, rd_addr_o, px_vld_o, px_idx_o, win_strt_o,
           out_row_o, out_col_o, frame_done_o, busy_o
  );
endinterface

// File: rtl/conv_window_sched.sv
// Convolution input scheduler: waits for a KSZ x KSZ window to be present in the
// input RAM, issues its reads in row-major order, starts the core and walks the
// output map position by position.
module conv_window_sched #(
  parameter int unsigned IMG_W  = 28,
  parameter int unsigned KSZ    = 3,
  parameter int unsigned ADDR_W = 10
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_sched_if.master bus
);

  localparam int unsigned NTAP       = KSZ * KSZ;
  localparam int unsigned TAP_W      = 4;
  localparam int unsigned POS_W      = 5;
  localparam int unsigned LAST_POS   = IMG_W - KSZ;
  localparam int unsigned ANCHOR_OFF = (KSZ - 1) * IMG_W + (KSZ - 1);
  localparam int unsigned CMP_W      = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [TAP_W-1:0]    kx_q, kx_d;
  logic [TAP_W-1:0]    ky_q, ky_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [POS_W-1:0]    row_q, row_d;
  logic [POS_W-1:0]    col_q, col_d;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                win_strt_q, win_strt_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                px_vld_q, px_vld_d;
  logic [TAP_W-1:0]    px_idx_q, px_idx_d;

  logic [CMP_W-1:0]    anchor_c;
  logic                avail_c;
  logic                last_win_c;

  // Window availability: last pixel of the current window already written
  always_comb begin
    anchor_c   = CMP_W'(base_q) + CMP_W'(ANCHOR_OFF);
    avail_c    = anchor_c < CMP_W'(bus.wr_cnt_i);
    last_win_c = (row_q == POS_W'(LAST_POS)) && (col_q == POS_W'(LAST_POS));
  end

  // Next-state, position walk and registered-output precompute
  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    base_d  = base_q;
    row_d   = row_q;
    col_d   = col_q;

    unique case (state_q)
      S_IDLE: begin
        if (avail_c && !bus.core_bsy_i) begin
          state_d = S_FETCH;
          tap_d   = '0;
          kx_d    = '0;
          ky_d    = '0;
        end
      end
      S_FETCH: begin
        if (tap_q == TAP_W'(NTAP - 1)) begin
          tap_d = '0;
          kx_d  = '0;
          ky_d  = '0;
          // Column wrap skips the KSZ-1 right-edge pixels plus the normal step
          if (col_q == POS_W'(LAST_POS)) begin
            col_d  = '0;
            row_d  = row_q + POS_W'(1);
            base_d = base_q + ADDR_W'(KSZ);
          end else begin
            col_d  = col_q + POS_W'(1);
            base_d = base_q + ADDR_W'(1);
          end
          state_d = last_win_c ? S_DONE : S_IDLE;
        end else begin
          tap_d = tap_q + TAP_W'(1);
          if (kx_q == TAP_W'(KSZ - 1)) begin
            kx_d = '0;
            ky_d = ky_q + TAP_W'(1);
          end else begin
            kx_d = kx_q + TAP_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the next state
    rd_en_d      = (state_d == S_FETCH);
    rd_addr_d    = rd_en_d ? base_q + ADDR_W'(32'(ky_d) * IMG_W + 32'(kx_d)) : '0;
    win_strt_d   = (state_q == S_IDLE) && (state_d == S_FETCH);
    frame_done_d = (state_q == S_FETCH) && (state_d == S_DONE);
    busy_d       = rd_en_d;
    // RAM read latency of one: tag the data returning next cycle
    px_vld_d     = rd_en_q;
    px_idx_d     = rd_en_q ? tap_q : '0;
  end

  // State, position and output registers; frame_clr restarts like reset
  always_ff @(posedge clk) begin
    if (rst || bus.frame_clr_i) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      kx_q         <= '0;
      ky_q         <= '0;
      base_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      win_strt_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      px_vld_q     <= 1'b0;
      px_idx_q     <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      kx_q         <= kx_d;
      ky_q         <= ky_d;
      base_q       <= base_d;
      row_q        <= row_d;
      col_q        <= col_d;
      rd_en_q      <= rd_en_d;
      rd_addr_q    <= rd_addr_d;
      win_strt_q   <= win_strt_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      px_vld_q     <= px_vld_d;
      px_idx_q     <= px_idx_d;
    end
  end

  assign bus.rd_en_o      = rd_en_q;
  assign bus.rd_addr_o    = rd_addr_q;
  assign bus.px_vld_o     = px_vld_q;
  assign bus.px_idx_o     = px_idx_q;
  assign bus.win_strt_o   = win_strt_q;
  assign bus.out_row_o    = row_q;
  assign bus.out_col_o    = col_q;
  assign bus.frame_done_o = frame_done_q;
  assign bus.busy_o       = busy_q;

endmodule
